// File: rtl/bus_router_if.sv
// -----------------------------------------------------------------------------
// bus_router_if
// Bundles the CPU-side request/response bus and the device-side strobe/return
// bus of bus_router.
//
// Modports:
//   slave  : router view (accepts CPU requests, drives device strobes,
//            receives per-device read returns)
//   master : environment view (CPU load/store unit plus device models)
//
// Signals:
//   bus_req_valid / bus_req_ready : request handshake
//   bus_addr, bus_wr_data, bus_wr_en : request payload
//   bus_rsp_valid, bus_rd_data, bus_rsp_err : one-cycle response
//   dev_sel (one-hot), dev_addr, dev_wr_data, dev_wr_en : device strobe
//   dev_rd_data (region i at [i*DATA_W +: DATA_W]), dev_rd_valid : device return
// -----------------------------------------------------------------------------
interface bus_router_if #(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned DATA_W      = 32
);
    logic                          bus_req_valid;
    logic                          bus_req_ready;
    logic [31:0]                   bus_addr;
    logic [DATA_W-1:0]             bus_wr_data;
    logic                          bus_wr_en;
    logic                          bus_rsp_valid;
    logic [DATA_W-1:0]             bus_rd_data;
    logic                          bus_rsp_err;

    logic [NUM_REGIONS-1:0]        dev_sel;
    logic [31:0]                   dev_addr;
    logic [DATA_W-1:0]             dev_wr_data;
    logic                          dev_wr_en;
    logic [NUM_REGIONS*DATA_W-1:0] dev_rd_data;
    logic [NUM_REGIONS-1:0]        dev_rd_valid;

    modport slave (
        input  bus_req_valid,
        output bus_req_ready,
        input  bus_addr,
        input  bus_wr_data,
        input  bus_wr_en,
        output bus_rsp_valid,
        output bus_rd_data,
        output bus_rsp_err,
        output dev_sel,
        output dev_addr,
        output dev_wr_data,
        output dev_wr_en,
        input  dev_rd_data,
        input  dev_rd_valid
    );

    modport master (
        output bus_req_valid,
        input  bus_req_ready,
        output bus_addr,
        output bus_wr_data,
        output bus_wr_en,
        input  bus_rsp_valid,
        input  bus_rd_data,
        input  bus_rsp_err,
        input  dev_sel,
        input  dev_addr,
        input  dev_wr_data,
        input  dev_wr_en,
        output dev_rd_data,
        output dev_rd_valid
    );
endinterface

// File: rtl/bus_router.sv
// -----------------------------------------------------------------------------
// bus_router
// Registered memory-map router: accepts one CPU transaction at a time over a
// valid/ready handshake, strobes the decoded device for one cycle, waits for
// that device's read-valid on reads, and returns a one-cycle response with
// data and an error flag (unmapped address or read timeout).
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : bus_router_if.slave (CPU request/response + device strobe/return)
//
// Parameters:
//   NUM_REGIONS, DATA_W, REGION_BASE[i], REGION_LOG2[i], TIMEOUT_CYCLES
//
// Build option:
//   BUS_ROUTER_TIMEOUT_EN : when defined, a read left unanswered for
//   TIMEOUT_CYCLES WAIT cycles completes with err=1 and data 0. When undefined
//   a read waits indefinitely for its device.
// -----------------------------------------------------------------------------
module bus_router #(
    parameter int unsigned NUM_REGIONS                   = 4,
    parameter int unsigned DATA_W                        = 32,
    parameter logic [31:0] REGION_BASE [NUM_REGIONS]     = '{32'd0, 32'd2048, 32'd131072, 32'd262144},
    parameter int unsigned REGION_LOG2 [NUM_REGIONS]     = '{10, 9, 17, 8},
    parameter int unsigned TIMEOUT_CYCLES                = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_router_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Transaction context latched at acceptance
    logic             hit_q;
    logic             wr_en_q;
    logic [IDX_W-1:0] region_q;

    // Registered outputs and their next values
    logic                   req_ready_q,   req_ready_d;
    logic                   rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]      rd_data_q,     rd_data_d;
    logic                   rsp_err_q,     rsp_err_d;
    logic [NUM_REGIONS-1:0] dev_sel_q,     dev_sel_d;
    logic [31:0]            dev_addr_q,    dev_addr_d;
    logic [DATA_W-1:0]      dev_wr_data_q, dev_wr_data_d;
    logic                   dev_wr_en_q,   dev_wr_en_d;

    // Decode of the live request address
    logic             hit_c;
    logic [IDX_W-1:0] region_c;
    logic [31:0]      offset_c;
    logic [31:0]      mask_c;

    // Read return of the latched region
    logic              sel_valid_c;
    logic [DATA_W-1:0] sel_data_c;

    logic timeout_c;

    // Address decode: first (lowest-index) matching region wins
    always_comb begin
        hit_c    = 1'b0;
        region_c = '0;
        offset_c = '0;
        mask_c   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            mask_c = 32'hFFFF_FFFF << REGION_LOG2[i];
            if (!hit_c && ((bus.bus_addr & mask_c) == (REGION_BASE[i] & mask_c))) begin
                hit_c    = 1'b1;
                region_c = IDX_W'(i);
                offset_c = bus.bus_addr & ~mask_c;
            end
        end
    end

    // Only the selected device's valid/data are observed
    always_comb begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_q == IDX_W'(i)) begin
                sel_valid_c = bus.dev_rd_valid[i];
                sel_data_c  = bus.dev_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Counts WAIT cycles; held at zero elsewhere so it starts clear on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle
    assign timeout_c = (state_q == S_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // WAIT never times out; the parameter stays on the port list for both builds
    localparam bit TIMEOUT_ZERO = (TIMEOUT_CYCLES == 0);

    assign timeout_c = TIMEOUT_ZERO & 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.bus_req_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Writes and misses finish immediately; a latency-0 device
                // answers in the ISSUE cycle itself
                if (!hit_q || wr_en_q || sel_valid_c) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_valid_c || timeout_c) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        req_ready_d   = (state_d == S_IDLE);
        rsp_valid_d   = (state_d == S_RESP);
        rd_data_d     = rd_data_q;
        rsp_err_d     = rsp_err_q;
        dev_sel_d     = '0;
        dev_addr_d    = '0;
        dev_wr_data_d = '0;
        dev_wr_en_d   = 1'b0;

        // Device strobe is launched at acceptance so it is live in ISSUE
        if ((state_q == S_IDLE) && bus.bus_req_valid && hit_c) begin
            dev_sel_d     = NUM_REGIONS'(1) << region_c;
            dev_addr_d    = offset_c;
            dev_wr_data_d = bus.bus_wr_data;
            dev_wr_en_d   = bus.bus_wr_en;
        end

        // Response payload is loaded only on the transition into RESP
        if ((state_q != S_RESP) && (state_d == S_RESP)) begin
            if (!hit_q) begin
                rd_data_d = '0;
                rsp_err_d = 1'b1;
            end else if (wr_en_q) begin
                rd_data_d = '0;
                rsp_err_d = 1'b0;
            end else if (sel_valid_c) begin
                rd_data_d = sel_data_c;
                rsp_err_d = 1'b0;
            end else begin
                rd_data_d = '0;
                rsp_err_d = 1'b1;
            end
        end
    end

    // Output and transaction-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rd_data_q     <= '0;
            rsp_err_q     <= 1'b0;
            dev_sel_q     <= '0;
            dev_addr_q    <= '0;
            dev_wr_data_q <= '0;
            dev_wr_en_q   <= 1'b0;
            hit_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            region_q      <= '0;
        end else begin
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rd_data_q     <= rd_data_d;
            rsp_err_q     <= rsp_err_d;
            dev_sel_q     <= dev_sel_d;
            dev_addr_q    <= dev_addr_d;
            dev_wr_data_q <= dev_wr_data_d;
            dev_wr_en_q   <= dev_wr_en_d;
            if ((state_q == S_IDLE) && bus.bus_req_valid) begin
                hit_q    <= hit_c;
                wr_en_q  <= bus.bus_wr_en;
                region_q <= region_c;
            end
        end
    end

    assign bus.bus_req_ready = req_ready_q;
    assign bus.bus_rsp_valid = rsp_valid_q;
    assign bus.bus_rd_data   = rd_data_q;
    assign bus.bus_rsp_err   = rsp_err_q;
    assign bus.dev_sel       = dev_sel_q;
    assign bus.dev_addr      = dev_addr_q;
    assign bus.dev_wr_data   = dev_wr_data_q;
    assign bus.dev_wr_en     = dev_wr_en_q;

endmodule

// File: tb/tb_bus_router.sv
// -----------------------------------------------------------------------------
// tb_bus_router
// Directed, table-driven bench for bus_router with hand-computed expectations,
// plus hand-written sequences for back-to-back throughput, reset during WAIT
// and (when BUS_ROUTER_TIMEOUT_EN is defined) the read watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_router;

    localparam int unsigned NUM_REGIONS    = 4;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bus_router_if #(.NUM_REGIONS(NUM_REGIONS), .DATA_W(DATA_W)) bif ();

    bus_router #(
        .NUM_REGIONS   (NUM_REGIONS),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd_lat;    // cycles after ISSUE the device asserts valid; -1 never
        logic [31:0] rdata;
        logic        noise;     // hold valid high on all other regions
        logic [3:0]  exp_sel;
        logic [31:0] exp_off;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;   // edges from handshake to response sample
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int rd_lat, input logic [31:0] rdata, input logic noise,
                                input logic [3:0] exp_sel, input logic [31:0] exp_off,
                                input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.rd_lat = rd_lat; v.rdata = rdata;
        v.noise = noise; v.exp_sel = exp_sel; v.exp_off = exp_off; v.exp_data = exp_data;
        v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic load_dev_data(input int tgt, input logic [31:0] val);
        for (int i = 0; i < NUM_REGIONS; i++) begin
            bif.dev_rd_data[i*DATA_W +: DATA_W] = 32'hBAD0_0000 | 32'(i);
        end
        if (tgt >= 0) begin
            bif.dev_rd_data[tgt*DATA_W +: DATA_W] = val;
        end
    endtask

    // One full transaction from IDLE back to IDLE
    task automatic run_txn(input vec_t v, input string tag);
        int         tgt;
        logic       got;
        logic       busy_ok;
        int         lat;
        logic [3:0] other;

        tgt = -1;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (v.exp_sel[i]) tgt = i;
        end
        other = v.noise ? ~v.exp_sel : 4'b0000;

        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(bif.bus_req_ready), 32'd1);
        bif.bus_req_valid = 1'b1;
        bif.bus_addr      = v.addr;
        bif.bus_wr_data   = v.wdata;
        bif.bus_wr_en     = v.wr;
        bif.dev_rd_valid  = '0;
        load_dev_data(tgt, v.rdata);

        @(posedge clk);
        #1;
        bif.bus_req_valid = 1'b0;
        chk({tag, "_dev_sel"}, 32'(bif.dev_sel), 32'(v.exp_sel));
        chk({tag, "_dev_wr_en"}, 32'(bif.dev_wr_en), 32'(v.wr && (v.exp_sel != 0)));
        if (v.exp_sel != 0) begin
            chk({tag, "_dev_addr"}, bif.dev_addr, v.exp_off);
        end
        if (v.wr && (v.exp_sel != 0)) begin
            chk({tag, "_dev_wr_data"}, bif.dev_wr_data, v.wdata);
        end
        bif.dev_rd_valid = other | ((v.rd_lat == 0) ? v.exp_sel : 4'b0000);

        got     = 1'b0;
        busy_ok = (bif.bus_req_ready === 1'b0);
        lat     = 0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(posedge clk);
            #1;
            bif.dev_rd_valid = other;
            if (n == 1) begin
                chk({tag, "_dev_sel_drop"}, 32'(bif.dev_sel), 32'd0);
            end
            if (bif.bus_req_ready !== 1'b0) busy_ok = 1'b0;
            if (bif.bus_rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = n + 1;
            end else if (n == v.rd_lat) begin
                bif.dev_rd_valid = other | v.exp_sel;
            end
        end
        bif.dev_rd_valid = '0;

        chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_ready_busy"}, 32'(busy_ok), 32'd1);
        chk({tag, "_rsp_err"}, 32'(bif.bus_rsp_err), 32'(v.exp_err));
        if (!v.wr) begin
            chk({tag, "_rd_data"}, bif.bus_rd_data, v.exp_data);
        end

        @(posedge clk);
        #1;
        chk({tag, "_rsp_one_cycle"}, 32'(bif.bus_rsp_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(bif.bus_req_ready), 32'd1);
        if (!v.wr) begin
            chk({tag, "_rd_data_hold"}, bif.bus_rd_data, v.exp_data);
        end
    endtask

    vec_t vecs[12];

    initial begin
        int accept[3];
        int n_acc;
        logic quiet;

        //            wr  addr           wdata          lat rdata          nz  sel      off           data           err lat
        vecs[0]  = mk(1, 32'h0000_0010, 32'hA5A5_0001, -1, 32'h0,         0, 4'b0001, 32'h10,      32'h0,         0,  2);
        vecs[1]  = mk(0, 32'h0000_0804, 32'h0,          0, 32'h0000_0ABC, 0, 4'b0010, 32'h4,       32'h0000_0ABC, 0,  2);
        vecs[2]  = mk(0, 32'h0002_0000, 32'h0,          5, 32'h1234_5678, 1, 4'b0100, 32'h0,       32'h1234_5678, 0,  7);
        vecs[3]  = mk(0, 32'h0000_0C00, 32'h0,         -1, 32'h0,         1, 4'b0000, 32'h0,       32'h0,         1,  2);
        vecs[4]  = mk(1, 32'h0004_0010, 32'hCAFE_0003, -1, 32'h0,         0, 4'b1000, 32'h10,      32'h0,         0,  2);
        vecs[5]  = mk(0, 32'h0004_00FF, 32'h0,          2, 32'hDEAD_BEEF, 1, 4'b1000, 32'hFF,      32'hDEAD_BEEF, 0,  4);
        vecs[6]  = mk(0, 32'h0000_03FC, 32'h0,          1, 32'h0000_0055, 0, 4'b0001, 32'h3FC,     32'h0000_0055, 0,  3);
        vecs[7]  = mk(0, 32'h0000_0400, 32'h0,         -1, 32'h0,         0, 4'b0000, 32'h0,       32'h0,         1,  2);
        vecs[8]  = mk(0, 32'h0000_09FC, 32'h0,          0, 32'h0000_0077, 1, 4'b0010, 32'h1FC,     32'h0000_0077, 0,  2);
        vecs[9]  = mk(0, 32'h0004_0100, 32'h0,         -1, 32'h0,         0, 4'b0000, 32'h0,       32'h0,         1,  2);
        vecs[10] = mk(1, 32'h0003_FFFF, 32'h0BAD_F00D, -1, 32'h0,         0, 4'b0100, 32'h1_FFFF,  32'h0,         0,  2);
        vecs[11] = mk(0, 32'h8000_0000, 32'h0,         -1, 32'h0,         0, 4'b0000, 32'h0,       32'h0,         1,  2);

        bif.bus_req_valid = 1'b0;
        bif.bus_addr      = '0;
        bif.bus_wr_data   = '0;
        bif.bus_wr_en     = 1'b0;
        bif.dev_rd_valid  = '0;
        load_dev_data(-1, 32'h0);

        // Reset values
        #12;
        chk("rst_ready", 32'(bif.bus_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bif.bus_rsp_valid), 32'd0);
        chk("rst_rd_data", bif.bus_rd_data, 32'd0);
        chk("rst_err", 32'(bif.bus_rsp_err), 32'd0);
        chk("rst_dev_sel", 32'(bif.dev_sel), 32'd0);
        chk("rst_dev_addr", bif.dev_addr, 32'd0);
        chk("rst_dev_wr_en", 32'(bif.dev_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back requests: accepted every third cycle
        n_acc = 0;
        accept[0] = -1; accept[1] = -1; accept[2] = -1;
        @(negedge clk);
        bif.bus_req_valid = 1'b1;
        bif.bus_addr      = 32'h0000_0020;
        bif.bus_wr_data   = 32'h1111_2222;
        bif.bus_wr_en     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (bif.bus_req_ready === 1'b1 && n_acc < 3) begin
                accept[n_acc] = c;
                n_acc++;
            end
        end
        bif.bus_req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd3);
        chk("b2b_gap1", 32'(accept[1] - accept[0]), 32'd3);
        chk("b2b_gap2", 32'(accept[2] - accept[1]), 32'd3);
        for (int c = 0; c < 10 && bif.bus_req_ready !== 1'b1; c++) begin
            @(negedge clk);
        end
        chk("b2b_idle", 32'(bif.bus_req_ready), 32'd1);

        // Reset while waiting on a read
        @(negedge clk);
        bif.bus_req_valid = 1'b1;
        bif.bus_addr      = 32'h0002_0000;
        bif.bus_wr_en     = 1'b0;
        @(posedge clk);
        #1;
        bif.bus_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rstw_busy", 32'(bif.bus_req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", 32'(bif.bus_req_ready), 32'd1);
        chk("rstw_rsp_valid", 32'(bif.bus_rsp_valid), 32'd0);
        chk("rstw_dev_sel", 32'(bif.dev_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[1], "after_rst");

`ifdef BUS_ROUTER_TIMEOUT_EN
        // Unanswered read times out; a late valid yields no second response
        run_txn(mk(0, 32'h0002_0000, 32'h0, -1, 32'h0, 0, 4'b0100, 32'h0, 32'h0, 1,
                   int'(TIMEOUT_CYCLES) + 2), "timeout");
        @(negedge clk);
        bif.dev_rd_valid = 4'b0100;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            bif.dev_rd_valid = '0;
            if (bif.bus_rsp_valid !== 1'b0) quiet = 1'b0;
        end
        chk("timeout_late_valid", 32'(quiet), 32'd1);
`else
        quiet = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
